pic_ctrl_seq: RTL and testbench

//  Synchronous, parametrised control sequencer for the 8259-style PIC: decodes
//  the ICW1..ICW4 init sequence and OCW1..OCW3 writes, and runs the INTA
//  two-pulse handshake that issues vector bytes. Sits between the CPU bus

---
 rtl/pic_ctrl_seq_if.sv | 14 +
 rtl/pic_ctrl_seq.sv | 210 +++++++++++++++++++++
 tb/tb_pic_ctrl_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_ctrl_seq_if.sv
// CPU-side bus of the PIC control sequencer: register writes, the INTA
// acknowledge pin, and the interrupt request / vector byte back to the CPU.
interface pic_ctrl_seq_if;
  logic       wr_en;
  logic       A0;
  logic [7:0] datain;
  logic       INTA;
  logic       INT;
  logic [7:0] vector_out;
  logic       vec_oe;

  modport master (output wr_en, A0, datain, INTA, input INT, vector_out, vec_oe);
  modport slave  (input wr_en, A0, datain, INTA, output INT, vector_out, vec_oe);
endinterface

// File: rtl/pic_ctrl_seq.sv
// 8259-style PIC control sequencer: ICW1..ICW4 init FSM, OCW1..OCW3 decode,
// and the two-pulse INTA handshake with auto-EOI and EOI collision handling.
module pic_ctrl_seq #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  localparam int L          = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  pic_ctrl_seq_if.slave      bus,
  input  logic               irq_pending,
  input  logic [L-1:0]       irq_id,
  output logic               isr_set,
  output logic [L-1:0]       isr_id,
  output logic               eoi_pulse,
  output logic               eoi_specific,
  output logic [L-1:0]       eoi_level,
  output logic [NUM_IRQ-1:0] maskreg,
  output logic [1:0]         RR_RIS,
  output logic               AEOI,
  output logic               SNGL,
  output logic [7:0]         ICW3word,
  output logic               init_done
);

  typedef enum logic [2:0] {S_UNINIT, S_ICW2, S_ICW3, S_ICW4, S_READY} init_state_t;
  typedef enum logic [1:0] {A_IDLE, A_ACK1, A_GAP, A_ACK2} inta_state_t;

  init_state_t init_state, init_next;
  inta_state_t inta_state, inta_next;

  logic         ic4;
  logic [7-L:0] vec_base;
  logic [L-1:0] cap_id;
  logic         spurious;
  logic         aeoi_pend;
  logic [L-1:0] pend_level;

  // ---------------- write decode ----------------
  logic icw1, wr_hi, ocw_lo, ocw2_eoi, ocw3_wr;

  assign init_done = (init_state == S_READY);
  assign icw1      = bus.wr_en & ~bus.A0 & bus.datain[4];
  assign wr_hi     = bus.wr_en &  bus.A0;
  assign ocw_lo    = bus.wr_en & ~bus.A0 & ~bus.datain[4] & init_done;
  assign ocw2_eoi  = ocw_lo & ~bus.datain[3] & bus.datain[5];
  assign ocw3_wr   = ocw_lo &  bus.datain[3];

  // ---------------- init FSM ----------------
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    init_next = init_state;
    if (icw1) begin
      init_next = S_ICW2;
    end else if (wr_hi) begin
      case (init_state)
        S_ICW2:  init_next = !SNGL ? S_ICW3 : (ic4 ? S_ICW4 : S_READY);
        S_ICW3:  init_next = ic4 ? S_ICW4 : S_READY;
        S_ICW4:  init_next = S_READY;
        default: init_next = init_state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_state <= S_UNINIT;
      vec_base   <= '0;
      SNGL       <= 1'b0;
      ic4        <= 1'b0;
      AEOI       <= 1'b0;
      ICW3word   <= '0;
      maskreg    <= '0;
      RR_RIS     <= 2'b10;
    end else begin
      init_state <= init_next;
      if (icw1) begin
        maskreg  <= '0;
        AEOI     <= 1'b0;
        ICW3word <= '0;
        RR_RIS   <= 2'b10;
        SNGL     <= bus.datain[1];
        ic4      <= bus.datain[0];
      end else if (wr_hi) begin
        case (init_state)
          S_ICW2:  vec_base <= bus.datain[7:L];
          S_ICW3:  ICW3word <= bus.datain;
          S_ICW4:  AEOI     <= bus.datain[1];
          S_READY: maskreg  <= bus.datain[NUM_IRQ-1:0];
          default: ;
        endcase
      end
      // OCW3 only updates the read select when its RR bit is set
      if (ocw3_wr && bus.datain[1]) RR_RIS <= bus.datain[1:0];
    end
  end

  // ---------------- INTA synchroniser and edge detect ----------------
  logic inta_s, inta_prev, inta_fall, inta_rise;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign inta_s = bus.INTA;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES:0]   taps;
      assign taps   = {sync_q, bus.INTA};
      assign inta_s = taps[SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= taps[SYNC_STAGES-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) inta_prev <= 1'b1;
    else       inta_prev <= inta_s;
  end

  assign inta_fall =  inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev &  inta_s;

  // ---------------- INTA FSM ----------------
  logic ack_start, vec_drive, ack_end, auto_req;

  always_comb begin
    inta_next = inta_state;
    ack_start = 1'b0;
    vec_drive = 1'b0;
    ack_end   = 1'b0;
    if (icw1) begin
      inta_next = A_IDLE;
    end else begin
      case (inta_state)
        A_IDLE: if (inta_fall) begin inta_next = A_ACK1; ack_start = 1'b1; end
        A_ACK1: if (inta_rise) inta_next = A_GAP;
        A_GAP:  if (inta_fall) begin inta_next = A_ACK2; vec_drive = 1'b1; end
        A_ACK2: if (inta_rise) begin inta_next = A_IDLE; ack_end = 1'b1; end
        default: inta_next = A_IDLE;
      endcase
    end
  end

  assign auto_req = ack_end & AEOI & ~spurious;
  assign isr_id   = cap_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      inta_state     <= A_IDLE;
      bus.INT        <= 1'b0;
      bus.vec_oe     <= 1'b0;
      bus.vector_out <= '0;
      isr_set        <= 1'b0;
      cap_id         <= '0;
      spurious       <= 1'b0;
    end else begin
      inta_state <= inta_next;
      isr_set    <= ack_start & irq_pending;
      bus.INT    <= (inta_state == A_IDLE) & ~ack_start & ~icw1 & irq_pending & init_done;
      if (ack_start) begin
        // With no request left at the first acknowledge, the lowest-priority id is returned
        cap_id   <= irq_pending ? irq_id : '1;
        spurious <= ~irq_pending;
      end
      if (vec_drive) begin
        bus.vec_oe     <= 1'b1;
        bus.vector_out <= {vec_base, cap_id};
      end
      if (ack_end || icw1) bus.vec_oe <= 1'b0;
    end
  end

  // ---------------- EOI arbitration ----------------
  // A CPU EOI wins the cycle; a colliding auto-EOI waits one cycle in aeoi_pend.
  always_ff @(posedge clk) begin
    if (reset) begin
      eoi_pulse    <= 1'b0;
      eoi_specific <= 1'b0;
      eoi_level    <= '0;
      aeoi_pend    <= 1'b0;
      pend_level   <= '0;
    end else begin
      eoi_pulse <= 1'b0;
      if (icw1) begin
        aeoi_pend <= 1'b0;
      end else if (ocw2_eoi) begin
        eoi_pulse    <= 1'b1;
        eoi_specific <= bus.datain[6];
        eoi_level    <= bus.datain[L-1:0];
        if (auto_req) begin
          aeoi_pend  <= 1'b1;
          pend_level <= cap_id;
        end
      end else if (aeoi_pend) begin
        eoi_pulse    <= 1'b1;
        eoi_specific <= 1'b1;
        eoi_level    <= pend_level;
        aeoi_pend    <= auto_req;
        if (auto_req) pend_level <= cap_id;
      end else if (auto_req) begin
        eoi_pulse    <= 1'b1;
        eoi_specific <= 1'b1;
        eoi_level    <= cap_id;
      end
    end
  end

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Directed bench for pic_ctrl_seq: one instance with NUM_IRQ=8/SYNC_STAGES=2,
// one with NUM_IRQ=4/SYNC_STAGES=0 for the short-latency collision case.
module tb_pic_ctrl_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pic_ctrl_seq_if bus_a ();
  pic_ctrl_seq_if bus_b ();

  logic       pend_a, pend_b;
  logic [2:0] id_a;
  logic [1:0] id_b;

  logic       isr_set_a, eoi_pulse_a, eoi_spec_a, aeoi_a, sngl_a, done_a;
  logic [2:0] isr_id_a, eoi_level_a;
  logic [7:0] mask_a, icw3_a;
  logic [1:0] rr_a;

  logic       isr_set_b, eoi_pulse_b, eoi_spec_b, aeoi_b, sngl_b, done_b;
  logic [1:0] isr_id_b, eoi_level_b;
  logic [3:0] mask_b;
  logic [7:0] icw3_b;
  logic [1:0] rr_b;

  pic_ctrl_seq #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .irq_pending(pend_a), .irq_id(id_a),
    .isr_set(isr_set_a), .isr_id(isr_id_a),
    .eoi_pulse(eoi_pulse_a), .eoi_specific(eoi_spec_a), .eoi_level(eoi_level_a),
    .maskreg(mask_a), .RR_RIS(rr_a), .AEOI(aeoi_a), .SNGL(sngl_a),
    .ICW3word(icw3_a), .init_done(done_a)
  );

  pic_ctrl_seq #(.NUM_IRQ(4), .SYNC_STAGES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .irq_pending(pend_b), .irq_id(id_b),
    .isr_set(isr_set_b), .isr_id(isr_id_b),
    .eoi_pulse(eoi_pulse_b), .eoi_specific(eoi_spec_b), .eoi_level(eoi_level_b),
    .maskreg(mask_b), .RR_RIS(rr_b), .AEOI(aeoi_b), .SNGL(sngl_b),
    .ICW3word(icw3_b), .init_done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit to_b, input logic a0, input logic [7:0] d);
    if (to_b) begin bus_b.wr_en = 1'b1; bus_b.A0 = a0; bus_b.datain = d; end
    else      begin bus_a.wr_en = 1'b1; bus_a.A0 = a0; bus_a.datain = d; end
    tick(1);
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  // Drives the INTA pin and waits out the SYNC_STAGES+1 cycle latency of that instance.
  task automatic inta(input bit to_b, input logic v);
    if (to_b) begin bus_b.INTA = v; tick(1); end
    else      begin bus_a.INTA = v; tick(3); end
  endtask

  initial begin
    reset = 1'b1;
    bus_a.wr_en = 1'b0; bus_a.A0 = 1'b0; bus_a.datain = '0; bus_a.INTA = 1'b1;
    bus_b.wr_en = 1'b0; bus_b.A0 = 1'b0; bus_b.datain = '0; bus_b.INTA = 1'b1;
    pend_a = 1'b0; id_a = '0; pend_b = 1'b0; id_b = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    check("rst_int",    bus_a.INT, 0);
    check("rst_vec_oe", bus_a.vec_oe, 0);
    check("rst_vector", bus_a.vector_out, 8'h00);
    check("rst_mask",   mask_a, 8'h00);
    check("rst_rr",     rr_a, 2'b10);
    check("rst_done",   done_a, 0);
    check("rst_eoi",    eoi_pulse_a, 0);
    check("rst_rr_b",   rr_b, 2'b10);

    // 1: ICW1=0x13, ICW2=0x40, ICW4=0x03, ICW3 skipped
    wr(0, 0, 8'h13);
    check("icw1_sngl", sngl_a, 1);
    check("icw1_done", done_a, 0);
    wr(0, 0, 8'h20);
    check("pre_ready_ocw2_ignored", eoi_pulse_a, 0);
    wr(0, 1, 8'h40);
    check("icw2_done", done_a, 0);
    wr(0, 1, 8'h03);
    check("icw4_done", done_a, 1);
    check("icw4_aeoi", aeoi_a, 1);
    check("icw3_skip", icw3_a, 8'h00);

    // 2: full handshake on channel 5 with auto-EOI
    pend_a = 1'b1; id_a = 3'd5;
    tick(1);
    check("int_assert", bus_a.INT, 1);
    inta(0, 0);
    check("ack1_int_drop", bus_a.INT, 0);
    check("ack1_isr_set", isr_set_a, 1);
    check("ack1_isr_id", isr_id_a, 3'd5);
    tick(1);
    check("isr_set_pulse", isr_set_a, 0);
    inta(0, 1);
    check("gap_no_oe", bus_a.vec_oe, 0);
    inta(0, 0);
    check("ack2_oe", bus_a.vec_oe, 1);
    check("ack2_vector", bus_a.vector_out, 8'h45);
    inta(0, 1);
    check("end_oe", bus_a.vec_oe, 0);
    check("aeoi_pulse", eoi_pulse_a, 1);
    check("aeoi_spec", eoi_spec_a, 1);
    check("aeoi_level", eoi_level_a, 3'd5);
    check("vector_hold", bus_a.vector_out, 8'h45);
    tick(1);
    check("aeoi_once", eoi_pulse_a, 0);
    check("int_reassert", bus_a.INT, 1);
    pend_a = 1'b0;
    tick(1);
    check("int_idle_low", bus_a.INT, 0);

    // 3: AEOI=0, OCW2 / OCW1 / OCW3 decode
    wr(0, 0, 8'h13); wr(0, 1, 8'h40); wr(0, 1, 8'h01);
    check("reinit_aeoi0", aeoi_a, 0);
    check("reinit_done", done_a, 1);
    wr(0, 0, 8'h20);
    check("ocw2_ns_pulse", eoi_pulse_a, 1);
    check("ocw2_ns_spec", eoi_spec_a, 0);
    tick(1);
    check("ocw2_pulse_end", eoi_pulse_a, 0);
    wr(0, 0, 8'h63);
    check("ocw2_sp_pulse", eoi_pulse_a, 1);
    check("ocw2_sp_spec", eoi_spec_a, 1);
    check("ocw2_sp_level", eoi_level_a, 3'd3);
    wr(0, 1, 8'hA5);
    check("ocw1_mask", mask_a, 8'hA5);
    wr(0, 0, 8'h0B);
    check("ocw3_rr_set", rr_a, 2'b11);
    wr(0, 0, 8'h09);
    check("ocw3_rr_hold", rr_a, 2'b11);

    // 4: spurious acknowledge
    wr(0, 0, 8'h13); wr(0, 1, 8'h40); wr(0, 1, 8'h03);
    check("icw1_mask_clr", mask_a, 8'h00);
    pend_a = 1'b1; id_a = 3'd2;
    tick(1);
    check("spur_int", bus_a.INT, 1);
    pend_a = 1'b0;
    inta(0, 0);
    check("spur_no_isr", isr_set_a, 0);
    check("spur_id", isr_id_a, 3'd7);
    inta(0, 1);
    inta(0, 0);
    check("spur_oe", bus_a.vec_oe, 1);
    check("spur_vector", bus_a.vector_out, 8'h47);
    inta(0, 1);
    check("spur_oe_off", bus_a.vec_oe, 0);
    check("spur_no_aeoi", eoi_pulse_a, 0);
    tick(1);
    check("spur_no_aeoi_late", eoi_pulse_a, 0);

    // 6a: OCW2 EOI on the auto-EOI cycle, SYNC_STAGES=2
    pend_a = 1'b1; id_a = 3'd6;
    inta(0, 0);
    check("col_a_isr_id", isr_id_a, 3'd6);
    inta(0, 1);
    inta(0, 0);
    check("col_a_vector", bus_a.vector_out, 8'h46);
    bus_a.INTA = 1'b1;
    tick(2);
    bus_a.wr_en = 1'b1; bus_a.A0 = 1'b0; bus_a.datain = 8'h20;
    tick(1);
    bus_a.wr_en = 1'b0;
    pend_a = 1'b0;
    check("col_a_first_pulse", eoi_pulse_a, 1);
    check("col_a_first_spec", eoi_spec_a, 0);
    tick(1);
    check("col_a_second_pulse", eoi_pulse_a, 1);
    check("col_a_second_spec", eoi_spec_a, 1);
    check("col_a_second_level", eoi_level_a, 3'd6);
    tick(1);
    check("col_a_done", eoi_pulse_a, 0);

    // 5: ICW1 written during GAP aborts the handshake
    wr(0, 1, 8'hFF);
    check("abort_mask_set", mask_a, 8'hFF);
    pend_a = 1'b1; id_a = 3'd1;
    inta(0, 0);
    check("abort_isr_set", isr_set_a, 1);
    inta(0, 1);
    wr(0, 0, 8'h13);
    check("abort_done", done_a, 0);
    check("abort_mask", mask_a, 8'h00);
    check("abort_aeoi", aeoi_a, 0);
    check("abort_int", bus_a.INT, 0);
    check("abort_eoi", eoi_pulse_a, 0);
    inta(0, 0);
    check("abort_no_oe", bus_a.vec_oe, 0);
    check("abort_back_idle", isr_set_a, 1);
    check("abort_int_uninit", bus_a.INT, 0);
    inta(0, 1);
    pend_a = 1'b0;

    // 6b: NUM_IRQ=4, SYNC_STAGES=0, init through ICW3
    wr(1, 0, 8'h11);
    check("b_sngl", sngl_b, 0);
    wr(1, 1, 8'h40);
    wr(1, 1, 8'h5A);
    check("b_icw3word", icw3_b, 8'h5A);
    check("b_icw3_not_done", done_b, 0);
    wr(1, 1, 8'h03);
    check("b_done", done_b, 1);
    check("b_aeoi", aeoi_b, 1);
    pend_b = 1'b1; id_b = 2'd2;
    tick(1);
    check("b_int", bus_b.INT, 1);
    inta(1, 0);
    check("b_int_drop", bus_b.INT, 0);
    check("b_isr_set", isr_set_b, 1);
    check("b_isr_id", isr_id_b, 2'd2);
    inta(1, 1);
    inta(1, 0);
    check("b_oe", bus_b.vec_oe, 1);
    check("b_vector", bus_b.vector_out, 8'h42);
    bus_b.INTA = 1'b1;
    bus_b.wr_en = 1'b1; bus_b.A0 = 1'b0; bus_b.datain = 8'h20;
    tick(1);
    bus_b.wr_en = 1'b0;
    pend_b = 1'b0;
    check("col_b_oe_off", bus_b.vec_oe, 0);
    check("col_b_first_pulse", eoi_pulse_b, 1);
    check("col_b_first_spec", eoi_spec_b, 0);
    tick(1);
    check("col_b_second_pulse", eoi_pulse_b, 1);
    check("col_b_second_spec", eoi_spec_b, 1);
    check("col_b_second_level", eoi_level_b, 2'd2);
    tick(1);
    check("col_b_done", eoi_pulse_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
